// File: rtl/hazard_stall_unit.sv
// EX-side hazard controller: load-use stall and taken-branch flush, each stretchable over several cycles.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_stall_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BR_FLUSH_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IFID_Rn,
    input  logic [4:0] IFID_Rm,
    input  logic       ID_Rn_valid,
    input  logic       ID_Rm_valid,
    input  logic [4:0] EX_Rd,
    input  logic       EX_read_enable,
    input  logic       EX_RegWrite,
    input  logic       EX_NOOP,
    input  logic       EX_BrTaken,
    output logic       PC_en,
    output logic       IFID_en,
    output logic       IFID_flush,
    output logic       IDEX_bubble,
    output logic       busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_LD_STALL = 2'd1;
    localparam logic [1:0] S_BR_FLUSH = 2'd2;

    localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] BR_RELOAD = 3'(BR_FLUSH_CYCLES - 1);
    localparam bit         LD_MULTI  = (LOAD_STALL_CYCLES > 1);
    localparam bit         BR_MULTI  = (BR_FLUSH_CYCLES > 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;
    logic       ld_hazard;
    logic       br;
    logic       pc_c;
    logic       ifid_en_c;
    logic       flush_c;
    logic       bubble_c;

    // XZR is never a real producer, and bubbles or non-writing loads never stall decode.
    assign ld_hazard = EX_read_enable & EX_RegWrite & ~EX_NOOP & (EX_Rd != 5'd31) &
                       ((ID_Rn_valid & (IFID_Rn == EX_Rd)) |
                        (ID_Rm_valid & (IFID_Rm == EX_Rd)));
    assign br = EX_BrTaken & ~EX_NOOP;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_c       = 1'b1;
        ifid_en_c  = 1'b1;
        flush_c    = 1'b0;
        bubble_c   = 1'b0;
        case (state)
            S_RUN: begin
                if (br) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (BR_MULTI) begin
                        state_next = S_BR_FLUSH;
                        cnt_next   = BR_RELOAD;
                    end
                end else if (ld_hazard) begin
                    pc_c      = 1'b0;
                    ifid_en_c = 1'b0;
                    bubble_c  = 1'b1;
                    if (LD_MULTI) begin
                        state_next = S_LD_STALL;
                        cnt_next   = LD_RELOAD;
                    end
                end
            end
            S_LD_STALL: begin
                bubble_c = 1'b1;
                // A taken branch makes the held decode instruction wrong-path: flush it now.
                if (br) begin
                    flush_c = 1'b1;
                    if (BR_MULTI) begin
                        state_next = S_BR_FLUSH;
                        cnt_next   = BR_RELOAD;
                    end else begin
                        state_next = S_RUN;
                        cnt_next   = 3'd0;
                    end
                end else begin
                    pc_c      = 1'b0;
                    ifid_en_c = 1'b0;
                    if (cnt <= 3'd1) begin
                        state_next = S_RUN;
                        cnt_next   = 3'd0;
                    end else begin
                        cnt_next = cnt - 3'd1;
                    end
                end
            end
            S_BR_FLUSH: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (cnt <= 3'd1) begin
                    state_next = S_RUN;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: begin
                state_next = S_RUN;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Reset holds the front end frozen and the ID/EX register bubbled.
    assign PC_en       = reset ? 1'b0 : pc_c;
    assign IFID_en     = reset ? 1'b0 : ifid_en_c;
    assign IFID_flush  = reset ? 1'b1 : flush_c;
    assign IDEX_bubble = reset ? 1'b1 : bubble_c;
    assign busy        = ~reset & (state != S_RUN);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_cycles <= 32'd0;
        end else begin
            if (!PC_en && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (IFID_flush && (flush_cycles != 32'hFFFF_FFFF)) begin
                flush_cycles <= flush_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: four parameterisations share one input bus and are checked against a
// cycle-window reference model, a vector table, and hand-written multi-cycle sequences.
module tb_hazard_stall_unit;

    logic       clk;
    logic       reset;
    logic [4:0] IFID_Rn;
    logic [4:0] IFID_Rm;
    logic       ID_Rn_valid;
    logic       ID_Rm_valid;
    logic [4:0] EX_Rd;
    logic       EX_read_enable;
    logic       EX_RegWrite;
    logic       EX_NOOP;
    logic       EX_BrTaken;

    logic        pc_en       [4];
    logic        ifid_en     [4];
    logic        ifid_flush  [4];
    logic        idex_bubble [4];
    logic        busy        [4];
    logic [31:0] stall_cnt   [4];
    logic [31:0] flush_cnt   [4];

    // Instance parameters: {LOAD_STALL_CYCLES, BR_FLUSH_CYCLES}
    int ls_cyc [4] = '{1, 3, 4, 7};
    int br_cyc [4] = '{1, 2, 3, 7};

    int checks = 0;
    int errors = 0;
    longint t_cyc = 0;
    longint flush_end [4];
    longint stall_end [4];
    logic [31:0] exp_stall [4];
    logic [31:0] exp_flush [4];

    hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .BR_FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm),
        .ID_Rn_valid(ID_Rn_valid), .ID_Rm_valid(ID_Rm_valid), .EX_Rd(EX_Rd),
        .EX_read_enable(EX_read_enable), .EX_RegWrite(EX_RegWrite), .EX_NOOP(EX_NOOP),
        .EX_BrTaken(EX_BrTaken), .PC_en(pc_en[0]), .IFID_en(ifid_en[0]),
        .IFID_flush(ifid_flush[0]), .IDEX_bubble(idex_bubble[0]), .busy(busy[0])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cnt[0]), .flush_cycles(flush_cnt[0])
`endif
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .BR_FLUSH_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm),
        .ID_Rn_valid(ID_Rn_valid), .ID_Rm_valid(ID_Rm_valid), .EX_Rd(EX_Rd),
        .EX_read_enable(EX_read_enable), .EX_RegWrite(EX_RegWrite), .EX_NOOP(EX_NOOP),
        .EX_BrTaken(EX_BrTaken), .PC_en(pc_en[1]), .IFID_en(ifid_en[1]),
        .IFID_flush(ifid_flush[1]), .IDEX_bubble(idex_bubble[1]), .busy(busy[1])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cnt[1]), .flush_cycles(flush_cnt[1])
`endif
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(4), .BR_FLUSH_CYCLES(3)) dut_c (
        .clk(clk), .reset(reset), .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm),
        .ID_Rn_valid(ID_Rn_valid), .ID_Rm_valid(ID_Rm_valid), .EX_Rd(EX_Rd),
        .EX_read_enable(EX_read_enable), .EX_RegWrite(EX_RegWrite), .EX_NOOP(EX_NOOP),
        .EX_BrTaken(EX_BrTaken), .PC_en(pc_en[2]), .IFID_en(ifid_en[2]),
        .IFID_flush(ifid_flush[2]), .IDEX_bubble(idex_bubble[2]), .busy(busy[2])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cnt[2]), .flush_cycles(flush_cnt[2])
`endif
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(7), .BR_FLUSH_CYCLES(7)) dut_d (
        .clk(clk), .reset(reset), .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm),
        .ID_Rn_valid(ID_Rn_valid), .ID_Rm_valid(ID_Rm_valid), .EX_Rd(EX_Rd),
        .EX_read_enable(EX_read_enable), .EX_RegWrite(EX_RegWrite), .EX_NOOP(EX_NOOP),
        .EX_BrTaken(EX_BrTaken), .PC_en(pc_en[3]), .IFID_en(ifid_en[3]),
        .IFID_flush(ifid_flush[3]), .IDEX_bubble(idex_bubble[3]), .busy(busy[3])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cnt[3]), .flush_cycles(flush_cnt[3])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %b expected %b", name, t_cyc, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, t_cyc, act, exp);
        end
    endtask

    // Reference model: each stall/flush is an absolute window of cycle numbers; a taken branch
    // outside a flush window opens a new flush window and cancels any stall window.
    task automatic model_check();
        logic e_pc, e_if, e_fl, e_bb, e_busy, in_f, in_s, br, ld;
        br = EX_BrTaken & ~EX_NOOP;
        ld = EX_read_enable & EX_RegWrite & ~EX_NOOP & (EX_Rd != 5'd31) &
             ((ID_Rn_valid & (IFID_Rn == EX_Rd)) | (ID_Rm_valid & (IFID_Rm == EX_Rd)));
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                {e_pc, e_if, e_fl, e_bb, e_busy} = 5'b00110;
                flush_end[i] = -1;
                stall_end[i] = -1;
                exp_stall[i] = 32'd0;
                exp_flush[i] = 32'd0;
            end else begin
                in_f   = (t_cyc <= flush_end[i]);
                in_s   = (t_cyc <= stall_end[i]);
                e_busy = in_f | in_s;
                if (in_f) begin
                    {e_pc, e_if, e_fl, e_bb} = 4'b1111;
                end else if (br) begin
                    {e_pc, e_if, e_fl, e_bb} = 4'b1111;
                    flush_end[i] = t_cyc + longint'(br_cyc[i]) - 1;
                    stall_end[i] = -1;
                end else if (in_s) begin
                    {e_pc, e_if, e_fl, e_bb} = 4'b0001;
                end else if (ld) begin
                    {e_pc, e_if, e_fl, e_bb} = 4'b0001;
                    stall_end[i] = t_cyc + longint'(ls_cyc[i]) - 1;
                end else begin
                    {e_pc, e_if, e_fl, e_bb} = 4'b1100;
                end
            end
            check($sformatf("pc_en[%0d]", i), pc_en[i], e_pc);
            check($sformatf("ifid_en[%0d]", i), ifid_en[i], e_if);
            check($sformatf("ifid_flush[%0d]", i), ifid_flush[i], e_fl);
            check($sformatf("idex_bubble[%0d]", i), idex_bubble[i], e_bb);
            check($sformatf("busy[%0d]", i), busy[i], e_busy);
`ifdef HAZARD_PERF_EN
            check32($sformatf("stall_cycles[%0d]", i), stall_cnt[i], exp_stall[i]);
            check32($sformatf("flush_cycles[%0d]", i), flush_cnt[i], exp_flush[i]);
            if (!reset) begin
                if (!e_pc && exp_stall[i] != 32'hFFFF_FFFF) exp_stall[i] = exp_stall[i] + 32'd1;
                if (e_fl && exp_flush[i] != 32'hFFFF_FFFF) exp_flush[i] = exp_flush[i] + 32'd1;
            end
`endif
        end
    endtask

    task automatic idle();
        IFID_Rn = 5'd0; IFID_Rm = 5'd0; ID_Rn_valid = 1'b0; ID_Rm_valid = 1'b0;
        EX_Rd = 5'd0; EX_read_enable = 1'b0; EX_RegWrite = 1'b0; EX_NOOP = 1'b1; EX_BrTaken = 1'b0;
    endtask

    task automatic set_ex(input logic [4:0] rn, input logic [4:0] rm, input logic rn_v,
                          input logic rm_v, input logic [4:0] rd, input logic re,
                          input logic rw, input logic noop, input logic brt);
        IFID_Rn = rn; IFID_Rm = rm; ID_Rn_valid = rn_v; ID_Rm_valid = rm_v;
        EX_Rd = rd; EX_read_enable = re; EX_RegWrite = rw; EX_NOOP = noop; EX_BrTaken = brt;
    endtask

    task automatic settle();
        #4;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        t_cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        settle();
        advance();
        reset = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd3;
            3: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    typedef struct {
        logic [4:0] rn;
        logic [4:0] rm;
        logic       rn_v;
        logic       rm_v;
        logic [4:0] rd;
        logic       re;
        logic       rw;
        logic       noop;
        logic       brt;
        logic       pc;
        logic       ifid;
        logic       flush;
        logic       bubble;
    } vec_t;

    vec_t tbl [12];
    logic seq_pc    [5];
    logic seq_flush [5];
    logic seq_busy  [5];

    initial begin
        reset = 1'b1;
        idle();
        // Each vector is independent on the single-cycle instance (dut_a).
        tbl[0]  = '{5'd3,  5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{5'd3,  5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{5'd0,  5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{5'd7,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{5'd7,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{5'd9,  5'd4,  1'b0, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{5'd6,  5'd6,  1'b1, 1'b1, 5'd6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{5'd4,  5'd4,  1'b1, 1'b1, 5'd4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{5'd10, 5'd11, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        do_reset();
        for (int k = 0; k < 12; k++) begin
            set_ex(tbl[k].rn, tbl[k].rm, tbl[k].rn_v, tbl[k].rm_v, tbl[k].rd,
                   tbl[k].re, tbl[k].rw, tbl[k].noop, tbl[k].brt);
            settle();
            check($sformatf("tbl%0d pc_en", k), pc_en[0], tbl[k].pc);
            check($sformatf("tbl%0d ifid_en", k), ifid_en[0], tbl[k].ifid);
            check($sformatf("tbl%0d ifid_flush", k), ifid_flush[0], tbl[k].flush);
            check($sformatf("tbl%0d idex_bubble", k), idex_bubble[0], tbl[k].bubble);
            check($sformatf("tbl%0d busy", k), busy[0], 1'b0);
            advance();
        end

        // 3-cycle load-use stall on X5 (dut_b)
        do_reset();
        seq_pc   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        seq_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            if (k == 0) set_ex(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
            else idle();
            settle();
            check($sformatf("ldstall c%0d pc_en", k), pc_en[1], seq_pc[k]);
            check($sformatf("ldstall c%0d busy", k), busy[1], seq_busy[k]);
            advance();
        end

        // branch and load-use together: branch wins, 2 flush cycles, no stall (dut_b)
        do_reset();
        seq_flush = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_busy  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            if (k < 2) set_ex(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
            else idle();
            settle();
            check($sformatf("brld c%0d pc_en", k), pc_en[1], 1'b1);
            check($sformatf("brld c%0d ifid_flush", k), ifid_flush[1], seq_flush[k]);
            check($sformatf("brld c%0d idex_bubble", k), idex_bubble[1], seq_flush[k]);
            check($sformatf("brld c%0d busy", k), busy[1], seq_busy[k]);
            advance();
        end

        // branch during the 2nd cycle of a 4-cycle stall aborts it (dut_c, 3 flush cycles)
        do_reset();
        seq_pc    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        seq_flush = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        seq_busy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_ex(5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            else if (k == 1) set_ex(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            else idle();
            settle();
            check($sformatf("ldabort c%0d pc_en", k), pc_en[2], seq_pc[k]);
            check($sformatf("ldabort c%0d ifid_flush", k), ifid_flush[2], seq_flush[k]);
            check($sformatf("ldabort c%0d busy", k), busy[2], seq_busy[k]);
            advance();
        end

        // asynchronous reset in the middle of a flush (dut_b)
        do_reset();
        set_ex(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        advance();
        idle();
        check("midflush busy", busy[1], 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async rst pc_en", pc_en[1], 1'b0);
        check("async rst ifid_flush", ifid_flush[1], 1'b1);
        check("async rst busy", busy[1], 1'b0);
`ifdef HAZARD_PERF_EN
        check32("async rst stall_cycles", stall_cnt[1], 32'd0);
        check32("async rst flush_cycles", flush_cnt[1], 32'd0);
`endif
        #1 model_check();
        advance();
        reset = 1'b0;
        settle();
        check("post rst busy", busy[1], 1'b0);
        check("post rst pc_en", pc_en[1], 1'b1);
        advance();

        // random traffic against the window model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_ex(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pick_reg(), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
